// File: rtl/ins_encoder.sv
// RV32I field packer: encodes instruction field bundles into machine words and
// streams them into IMEM at consecutive word addresses starting at BASE_ADDR.
module ins_encoder #(
   parameter int                 ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
   parameter int                 DEPTH     = 256,
   localparam int                CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        op,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [4:0]        rd,
   input  logic [31:0]       imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              done,
   output logic              bad_op
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} state_t;

   state_t      state, state_nx;
   logic        accept, op_ok, cnt_last;
   logic [31:0] word;

   assign in_ready = (state == S_RUN) && (!mem_we || mem_ready) && !start;
   assign accept   = in_valid && in_ready;
   assign cnt_last = (count == CNT_W'(DEPTH - 1));
   assign full     = (count == CNT_W'(DEPTH));
   assign done     = full && !mem_we;

   // Field packing; opcodes outside the supported set are flagged, not written.
   always_comb begin
      word  = '0;
      op_ok = 1'b1;
      case (op)
         7'b0110011: word = {funct7, rs2, rs1, funct3, rd, op};
         7'b0010011: begin
            if (funct3 == 3'b001 || funct3 == 3'b101)
               word = {funct7, imm[4:0], rs1, funct3, rd, op};
            else
               word = {imm[11:0], rs1, funct3, rd, op};
         end
         7'b0000011,
         7'b1100111: word = {imm[11:0], rs1, funct3, rd, op};
         7'b0100011: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
         7'b1100011: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
         7'b0110111,
         7'b0010111: word = {imm[31:12], rd, op};
         7'b1101111: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         default:    op_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_nx = state;
      if (start)
         state_nx = S_RUN;
      else if (state == S_RUN && accept && op_ok && cnt_last)
         state_nx = S_FULL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // start wins over everything: a stalled write is abandoned, not completed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we    <= 1'b0;
         mem_addr  <= BASE_ADDR;
         mem_wdata <= '0;
         count     <= '0;
         bad_op    <= 1'b0;
      end else if (start) begin
         mem_we   <= 1'b0;
         mem_addr <= BASE_ADDR;
         count    <= '0;
         bad_op   <= 1'b0;
      end else begin
         if (accept && op_ok) begin
            mem_we    <= 1'b1;
            mem_addr  <= BASE_ADDR + ADDR_W'({count, 2'b00});
            mem_wdata <= word;
            count     <= count + 1'b1;
         end else if (mem_ready) begin
            mem_we <= 1'b0;
         end
         if (accept && !op_ok)
            bad_op <= 1'b1;
      end
   end

endmodule
